// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event path.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  // One queued key event; is_release=0 for a press.
  typedef struct packed {
    logic                  is_release;
    logic [KEY_CODE_W-1:0] code;
  } key_evt_t;

  // Index of the lowest set bit (0 when no bit is set).
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [15:0] v);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/kp_sync_fifo.sv
// First-word-fall-through FIFO of key events.
// The head entry is visible on dout_o whenever valid_o is high; dout_o is
// forced to zero while empty so stale storage never leaks out.
module kp_sync_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  key_evt_t      din_i,
  input  logic          pop_i,
  output logic          valid_o,
  output key_evt_t      dout_o,
  output logic [AW:0]   count_o
);

  key_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  assign valid_o = (count_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Next-state for pointers and occupancy; DEPTH is a power of two so
  // pointer increments wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // Pointer/count state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; a push into a full FIFO with a pop lands in the slot being read
  // out this same cycle, which is safe because the read is combinational.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad event queue: resynchronises debounced key levels, detects press
// edges, holds them in per-key pending bits and feeds one event per cycle
// into an FWFT FIFO. Define KEYPAD_RELEASE_EVT_EN to also queue release
// events; otherwise evt_release stays 0.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int N_KEYS      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_KEYS-1:0]             btn_in,
  output logic                          evt_valid,
  output logic [3:0]                    evt_code,
  output logic                          evt_release,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0][N_KEYS-1:0] sync_q;
  logic [N_KEYS-1:0] btn_s, btn_q;
  logic [N_KEYS-1:0] press_edge, pend_press_q, pend_press_d;
  logic [N_KEYS-1:0] sel_mask, press_clr;
  logic [15:0]       scan_vec;
  logic [3:0]        sel_idx;
  logic              sel_rel, any_pend, full, pop, push, loss;
  logic              overflow_q, overflow_d;
  key_evt_t          push_evt, head_evt;

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [N_KEYS-1:0] release_edge, pend_rel_q, pend_rel_d, rel_clr;
`endif

  assign btn_s      = sync_q[SYNC_STAGES-1];
  assign press_edge = btn_s & ~btn_q;

  // Resync chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      btn_q  <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_q <= btn_s;
    end
  end

  // Count MSB is only set at exactly FIFO_DEPTH entries.
  assign full = evt_count[AW];
  assign pop  = evt_valid & evt_ready;

  // Pick the lowest pending key; on a key with both kinds pending the press
  // goes first.
  always_comb begin
`ifdef KEYPAD_RELEASE_EVT_EN
    scan_vec = 16'(pend_press_q | pend_rel_q);
`else
    scan_vec = 16'(pend_press_q);
`endif
    any_pend = |scan_vec;
    sel_idx  = lowest_set(scan_vec);
`ifdef KEYPAD_RELEASE_EVT_EN
    sel_rel  = ~pend_press_q[sel_idx];
`else
    sel_rel  = 1'b0;
`endif
    push     = any_pend & (~full | pop);
    sel_mask = {{(N_KEYS-1){1'b0}}, 1'b1} << sel_idx;
    push_evt.is_release = sel_rel;
    push_evt.code       = sel_idx;
  end

  // Pending update and loss detection: an edge on a key still pending (and
  // not leaving this cycle) is merged and flagged.
  always_comb begin
    press_clr    = (push && !sel_rel) ? sel_mask : '0;
    pend_press_d = (pend_press_q & ~press_clr) | press_edge;
    loss         = |(press_edge & pend_press_q & ~press_clr);
`ifdef KEYPAD_RELEASE_EVT_EN
    release_edge = ~btn_s & btn_q;
    rel_clr      = (push && sel_rel) ? sel_mask : '0;
    pend_rel_d   = (pend_rel_q & ~rel_clr) | release_edge;
    loss         = loss | (|(release_edge & pend_rel_q & ~rel_clr));
`endif
    overflow_d = overflow_q;
    if (loss)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Pending bits and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_press_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_press_q <= pend_press_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  // Pending release bits.
  always_ff @(posedge clk) begin
    if (rst) pend_rel_q <= '0;
    else     pend_rel_q <= pend_rel_d;
  end
`endif

  kp_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_evt),
    .pop_i   (pop),
    .valid_o (evt_valid),
    .dout_o  (head_evt),
    .count_o (evt_count)
  );

  assign evt_code    = head_evt.code;
  assign evt_release = head_evt.is_release;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue. Inputs are driven and outputs
// sampled on the falling edge. Build with +define+KEYPAD_RELEASE_EVT_EN to
// check the release-event variant.
module tb_keypad_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] btn_in;
  logic        evt_valid, evt_release, evt_ready, overflow, clr_overflow;
  logic [3:0]  evt_code;
  logic [3:0]  evt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_event_queue #(.N_KEYS(16), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_release  (evt_release),
    .evt_ready    (evt_ready),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; btn_in = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    checks++; if (evt_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", evt_code); end
    checks++; if (evt_release !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", evt_release); end
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single_press;
    do_reset;
    btn_in = 16'h0010;
    repeat (3) tick;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early got valid=%b want 0", evt_valid); end
    tick;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", evt_valid); end
    checks++; if (evt_code !== 4'd4) begin errors++; $display("FAIL single_code got %0d want 4", evt_code); end
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", evt_count); end
    repeat (10) tick;
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL single_held got count=%0d want 1", evt_count); end
  endtask

  task automatic test_simultaneous;
    int exp_code[3] = '{0, 2, 15};
    do_reset;
    btn_in = 16'h8005; evt_ready = 1'b1;
    repeat (4) tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 4'(exp_code[i]) || evt_count !== 4'd1) begin
        errors++;
        $display("FAIL simul_evt%0d got v=%b code=%0d cnt=%0d want v=1 code=%0d cnt=1",
                 i, evt_valid, evt_code, evt_count, exp_code[i]);
      end
      tick;
    end
    checks++; if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin errors++; $display("FAIL simul_drain got v=%b cnt=%0d want 0/0", evt_valid, evt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %b want 0", overflow); end
    evt_ready = 1'b0;
  endtask

  task automatic test_full;
    do_reset;
    for (int k = 0; k <= 8; k++) begin
      btn_in[k] = 1'b1;
      repeat (4) tick;
    end
    repeat (4) tick;
    checks++; if (evt_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", evt_count); end
    checks++; if (evt_code !== 4'd0) begin errors++; $display("FAIL full_head got %0d want 0", evt_code); end
    evt_ready = 1'b1; tick; evt_ready = 1'b0;
    checks++; if (evt_count !== 4'd8) begin errors++; $display("FAIL full_after_pop_count got %0d want 8", evt_count); end
    checks++; if (evt_code !== 4'd1) begin errors++; $display("FAIL full_after_pop_head got %0d want 1", evt_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b want 0", overflow); end
    evt_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 4'(i)) begin
        errors++; $display("FAIL full_drain%0d got v=%b code=%0d want v=1 code=%0d", i, evt_valid, evt_code, i);
      end
      tick;
    end
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL full_empty got %0d want 0", evt_count); end
    evt_ready = 1'b0;
  endtask

  task automatic test_loss;
    int fill[8]  = '{0, 1, 2, 4, 5, 6, 7, 8};
    int order[9] = '{0, 1, 2, 4, 5, 6, 7, 8, 3};
    do_reset;
    for (int i = 0; i < 8; i++) begin
      btn_in[fill[i]] = 1'b1;
      repeat (4) tick;
    end
    btn_in[3] = 1'b1;
    repeat (4) tick;
    checks++; if (evt_count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL loss_setup got cnt=%0d ovf=%b want 8/0", evt_count, overflow); end
    btn_in[3] = 1'b0; repeat (4) tick;
    btn_in[3] = 1'b1; repeat (4) tick;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loss_set got %b want 1", overflow); end
    clr_overflow = 1'b1; tick; clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL loss_clr got %b want 0", overflow); end
    btn_in[3] = 1'b0; repeat (4) tick;
    btn_in[3] = 1'b1; tick; tick;
    clr_overflow = 1'b1; tick; clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loss_set_vs_clr got %b want 1", overflow); end
    tick;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL loss_sticky got %b want 1", overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 4'(order[i]) || evt_release !== 1'b0) begin
        errors++;
        $display("FAIL loss_drain%0d got v=%b code=%0d rel=%b want v=1 code=%0d rel=0",
                 i, evt_valid, evt_code, evt_release, order[i]);
      end
      tick;
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_midop;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      btn_in = 16'(1 << k); repeat (4) tick;
      btn_in = '0;          repeat (4) tick;
    end
    btn_in = 16'h0010; repeat (6) tick;
`ifdef KEYPAD_RELEASE_EVT_EN
    checks++; if (evt_count !== 4'd8) begin errors++; $display("FAIL midop_pre got %0d want 8", evt_count); end
`else
    checks++; if (evt_count !== 4'd5) begin errors++; $display("FAIL midop_pre got %0d want 5", evt_count); end
`endif
    rst = 1'b1; tick; rst = 1'b0;
    checks++; if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin errors++; $display("FAIL midop_rst got v=%b cnt=%0d want 0/0", evt_valid, evt_count); end
    repeat (8) tick;
    checks++; if (evt_valid !== 1'b1 || evt_code !== 4'd4 || evt_count !== 4'd1) begin errors++; $display("FAIL midop_held got v=%b code=%0d cnt=%0d want 1/4/1", evt_valid, evt_code, evt_count); end
    repeat (8) tick;
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL midop_once got %0d want 1", evt_count); end
    evt_ready = 1'b1; tick; evt_ready = 1'b0;
    checks++; if (evt_count !== 4'd0) begin errors++; $display("FAIL midop_pop got %0d want 0", evt_count); end
  endtask

  task automatic test_release;
    do_reset;
    btn_in = 16'h0080; repeat (6) tick;
    btn_in = 16'h0000; repeat (6) tick;
    checks++; if (evt_code !== 4'd7 || evt_release !== 1'b0) begin errors++; $display("FAIL rel_first got code=%0d rel=%b want 7/0", evt_code, evt_release); end
`ifdef KEYPAD_RELEASE_EVT_EN
    checks++; if (evt_count !== 4'd2) begin errors++; $display("FAIL rel_count got %0d want 2", evt_count); end
    evt_ready = 1'b1; tick; evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b1 || evt_code !== 4'd7 || evt_release !== 1'b1) begin errors++; $display("FAIL rel_second got v=%b code=%0d rel=%b want 1/7/1", evt_valid, evt_code, evt_release); end
`else
    checks++; if (evt_count !== 4'd1) begin errors++; $display("FAIL rel_count got %0d want 1", evt_count); end
    evt_ready = 1'b1; tick; evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin errors++; $display("FAIL rel_none got v=%b cnt=%0d want 0/0", evt_valid, evt_count); end
`endif
  endtask

  initial begin
    rst = 1'b1; btn_in = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    test_reset;
    test_single_press;
    test_simultaneous;
    test_full;
    test_loss;
    test_reset_midop;
    test_release;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
